// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FIFO: defaults, access-type
// encoding, a clog2 helper and an elaboration-time parameter check.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

package fifo_pkg;

  localparam int unsigned FIFO_WIDTH_DEF = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 16;

  // Kind of access accepted in a cycle; drives the count update.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Ceiling log2, valid for v >= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// Flags a non-power-of-two / too-small depth or thresholds outside 0..DEPTH.
`define FIFO_PARAM_CHECK(D, AF, AE) \
  if ((D) < 2 || (((D) & ((D) - 1)) != 0) || \
      (AF) < 0 || (AF) > (D) || (AE) < 0 || (AE) > (D)) begin : g_param_err \
    $error("fifo_param: illegal DEPTH/AF_LEVEL/AE_LEVEL"); \
  end

`endif

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port and one
// registered read port whose output register resets to zero.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  // Next storage contents and next read register value.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
    rdata_d = re ? mem_q[raddr] : rdata_q;
  end

  // Storage is not reset; contents after reset are don't-care.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Read register holds its value between reads and clears on reset.
  always_ff @(posedge clk) begin
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO: circular pointers, explicit occupancy
// count, almost-full/empty thresholds and sticky overflow/underflow flags.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_WIDTH_DEF,
  parameter int DEPTH    = FIFO_DEPTH_DEF,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   en_write,
  input  logic                   en_read,
  input  logic                   err_clr,
  output logic [WIDTH-1:0]       data_out,
  output logic                   data_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [clog2(DEPTH):0]  count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  `FIFO_PARAM_CHECK(DEPTH, AF_LEVEL, AE_LEVEL)

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic     rd_acc, wr_acc;
  fifo_op_e op;

  // Acceptance decisions; a read frees the slot a write at full needs.
  always_comb begin
    rd_acc = en_read && (count_q != '0);
    wr_acc = en_write && ((count_q != DEPTH_C) || rd_acc);
    op     = fifo_op_e'({rd_acc, wr_acc});
  end

  // Next pointers, count, valid strobe and sticky error flags.
  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case (op)
      OP_WR:   count_d = count_q + CW'(1);
      OP_RD:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    valid_d = rd_acc;
    // A new error in the same cycle as err_clr keeps the flag set.
    ovf_d = err_clr ? 1'b0 : ovf_q;
    if (en_write && !wr_acc) ovf_d = 1'b1;
    udf_d = err_clr ? 1'b0 : udf_q;
    if (en_read && !rd_acc) udf_d = 1'b1;
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wr_acc && reset_n),
    .waddr   (wr_ptr_q),
    .wdata   (data_in),
    .re      (rd_acc && reset_n),
    .raddr   (rd_ptr_q),
    .rdata   (data_out)
  );

  assign data_valid   = valid_q;
  assign count        = count_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Scoreboard bench for fifo_param (WIDTH=8, DEPTH=16): expected read data is
// queued as reads are issued and popped by a monitor on each data_valid.
module tb_fifo_param;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] data_in;
  logic       en_write, en_read, err_clr;
  logic [7:0] data_out;
  logic       data_valid, full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  fifo_param #(
    .WIDTH    (8),
    .DEPTH    (16),
    .AF_LEVEL (14),
    .AE_LEVEL (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_in      (data_in),
    .en_write     (en_write),
    .en_read      (en_read),
    .err_clr      (err_clr),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every valid word must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset_n && data_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got data 0x%0h expected no valid", data_out);
      end else begin
        chk("read_data", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    en_write = 1'b0;
    en_read  = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    data_in  = d;
    en_write = 1'b1;
    step();
  endtask

  task automatic rd(input logic [7:0] expd);
    exp_q.push_back(expd);
    en_read = 1'b1;
    step();
  endtask

  task automatic chk_reset_state();
    chk("rst_count",    {27'd0, count}, 32'd0);
    chk("rst_empty",    {31'd0, empty}, 32'd1);
    chk("rst_full",     {31'd0, full}, 32'd0);
    chk("rst_ae",       {31'd0, almost_empty}, 32'd1);
    chk("rst_af",       {31'd0, almost_full}, 32'd0);
    chk("rst_ovf",      {31'd0, overflow}, 32'd0);
    chk("rst_udf",      {31'd0, underflow}, 32'd0);
    chk("rst_data_out", {24'd0, data_out}, 32'd0);
    chk("rst_valid",    {31'd0, data_valid}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; data_in = '0; en_write = 1'b0; en_read = 1'b0; err_clr = 1'b0;
    step(); step();
    reset_n = 1'b1;
    chk_reset_state();

    // Fill 0x01..0x10; almost_full first at count 14.
    for (int i = 1; i <= 16; i++) begin
      wr(8'(i));
      chk("fill_count", {27'd0, count}, i);
      chk("fill_af", {31'd0, almost_full}, (i >= 14) ? 32'd1 : 32'd0);
    end
    chk("fill_full", {31'd0, full}, 32'd1);
    wr(8'hAA);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_count", {27'd0, count}, 32'd16);

    // Sticky flag clearing, and error winning over a simultaneous clear.
    err_clr = 1'b1; step();
    chk("ovf_clr", {31'd0, overflow}, 32'd0);
    err_clr = 1'b1; wr(8'hAB);
    chk("ovf_clr_vs_err", {31'd0, overflow}, 32'd1);
    err_clr = 1'b1; step();

    // Drain in order, then a rejected read.
    for (int i = 1; i <= 16; i++) rd(8'(i));
    chk("drain_empty", {31'd0, empty}, 32'd1);
    en_read = 1'b1; step();
    chk("udf_set", {31'd0, underflow}, 32'd1);
    chk("udf_valid", {31'd0, data_valid}, 32'd0);
    chk("udf_hold", {24'd0, data_out}, 32'h10);
    err_clr = 1'b1; step();

    // Wrap-around batches.
    for (int i = 0; i < 10; i++) wr(8'(8'h20 + i));
    for (int i = 0; i < 10; i++) rd(8'(8'h20 + i));
    for (int i = 0; i < 12; i++) wr(8'(8'h40 + i));
    chk("wrap_count12", {27'd0, count}, 32'd12);
    for (int i = 0; i < 12; i++) rd(8'(8'h40 + i));
    chk("wrap_count0", {27'd0, count}, 32'd0);

    // Simultaneous read/write at full.
    for (int i = 0; i < 16; i++) wr(8'(8'h60 + i));
    exp_q.push_back(8'h60);
    data_in = 8'h55; en_write = 1'b1; en_read = 1'b1; step();
    chk("both_full_count", {27'd0, count}, 32'd16);
    chk("both_full_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 1; i < 16; i++) rd(8'(8'h60 + i));
    rd(8'h55);
    chk("both_drain_empty", {31'd0, empty}, 32'd1);

    // Simultaneous read/write at empty: no fall-through.
    data_in = 8'h77; en_write = 1'b1; en_read = 1'b1; step();
    chk("both_empty_count", {27'd0, count}, 32'd1);
    chk("both_empty_udf", {31'd0, underflow}, 32'd1);
    chk("both_empty_valid", {31'd0, data_valid}, 32'd0);
    rd(8'h77);
    err_clr = 1'b1; step();

    // Mid-operation reset with inputs active.
    for (int i = 0; i < 7; i++) wr(8'(8'h80 + i));
    chk("pre_rst_count", {27'd0, count}, 32'd7);
    chk("pre_rst_ae", {31'd0, almost_empty}, 32'd0);
    reset_n = 1'b0; data_in = 8'hEE; en_write = 1'b1; en_read = 1'b1; step();
    reset_n = 1'b1;
    chk_reset_state();
    wr(8'h3C);
    chk("post_rst_count", {27'd0, count}, 32'd1);
    rd(8'h3C);

    step(); step();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO, the next generation of the team's 8-bit × 16 FIFO. Generalised in data width and depth, with a circular-buffer pointer scheme, a registered read port with a valid strobe, and an occupancy count. Adds programmable almost-full/almost-empty thresholds and sticky, software-clearable overflow/underflow flags. Sits between producer and consumer logic in the same clock domain.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL
- clk  input  1  rising-edge clock, single domain
- reset_n  input  1  synchronous, active-low reset
- data_in  input  WIDTH  write data
- en_write  input  1  write request
- en_read  input  1  read request
- err_clr  input  1  clears the sticky overflow/underflow flags
- data_out  output  WIDTH  registered read data
- data_valid  output  1  data_out was updated by an accepted read this cycle
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count ≥ AF_LEVEL
- almost_empty  output  1  count ≤ AE_LEVEL
- count  output  $clog2(DEPTH)+1  current occupancy
- overflow  output  1  sticky: a write was dropped
- underflow  output  1  sticky: a read was rejected

## Operation
- Storage is a DEPTH-entry array with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping naturally from DEPTH-1 to 0. count is an explicit register, not derived from the pointers.
- Write accepted = en_write && (!full || read accepted). On acceptance: mem[wr_ptr] ← data_in, wr_ptr+1.
- Read accepted = en_read && !empty. On acceptance: data_out ← mem[rd_ptr], rd_ptr+1.
- count update: +1 on write only, −1 on read only, unchanged on both or neither.
- Full with en_write and en_read both high: both are accepted, count stays DEPTH, and there is no overflow.
- Empty with en_write and en_read both high: the write is accepted, the read is rejected, underflow is set, and count becomes 1. There is no fall-through.
- Rejected write (full, no read): data is dropped, pointers are unchanged, overflow ← 1.
- Rejected read (empty): data_out holds its previous value, data_valid stays 0, underflow ← 1.
- data_out holds its last value when no read is accepted. It never returns to zero except on reset.
- err_clr clears both sticky flags. A new error in the same cycle as err_clr wins, and the flag stays 1.
- Reset (reset_n=0 at a clock edge), including mid-operation:
  - pointers and count go to 0
  - data_out and data_valid go to 0
  - overflow and underflow go to 0
  - storage contents are not cleared and are don't-care
  - en_write and en_read are ignored during reset

## Timing
- All outputs are registered or derived from registered count. No combinational path from inputs to outputs.
- Write-to-read latency: a word written at edge N is readable (empty=0) after edge N. A read requested at edge N+1 presents the word on data_out with data_valid=1 after edge N+1.
- Read latency is 1 cycle. data_valid is a single-cycle pulse per accepted read. Back-to-back reads give back-to-back valid data.
- full, empty, almost_full, almost_empty and count all reflect the state after the current edge.
- Reset values:
  - data_out=0, data_valid=0, count=0
  - empty=1, full=0
  - almost_empty=1, almost_full=0
  - overflow=0, underflow=0

## Structure
- Shared package fifo_pkg holds:
  - default WIDTH/DEPTH constants
  - a clog2 helper function
  - a parameter-check macro that flags a non-power-of-two DEPTH or AF_LEVEL/AE_LEVEL outside 0..DEPTH at elaboration
- Sub-module fifo_mem: a DEPTH×WIDTH register array with one synchronous write port and one synchronous registered read port. fifo_param contains the pointers, count, flags and control.

## Test plan
- Reset, then write 0x01..0x10 (16 words, DEPTH=16):
  - full=1 and count=16 after the 16th edge
  - almost_full first asserts at count=14
  - a 17th write of 0xAA sets overflow=1 and count stays 16
- From full, read 16 times: data_out=0x01..0x10 in order, data_valid=1 each cycle, empty=1 at the end. A 17th read sets underflow=1 and data_out holds 0x10.
- Wrap-around: write 10, read 10, then write 12 and read 12. The second batch comes out in order across the pointer wrap, and count returns to 0.
- Simultaneous access: at full, en_write=en_read=1 with data_in=0x55 gives count=16, no overflow, and 0x55 appears as the last word out. At empty, both high gives count=1 and underflow=1.
- Sticky flags:
  - with overflow=1, pulse err_clr and the flag returns to 0
  - err_clr in the same cycle as a rejected write leaves overflow=1
- Mid-operation reset: with count=7, drive reset_n=0 for 1 edge. All outputs return to their reset values, then a write of 0x3C followed by a read returns 0x3C.
